// File: rtl/all_taps.sv
// Equalizer tap generator: eight 16-bit taps are computed serially into a staging
// register, then committed to allTaps in one transfer. Define ALL_TAPS_ROUND_EN for round-half-up taps.
module all_taps (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   eqVal,
   output logic [127:0] allTaps
);

   typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

   state_t       state;
   logic [7:0]   eq_q;
   logic         eq_valid;
   logic [2:0]   cnt;
   logic [127:0] stage;
   logic         busy;

   assign busy = (state != IDLE);

   // The 20-bit intermediate holds 7 << 15 plus the rounding bias with room to spare.
   function automatic logic [15:0] tap_val(input logic [2:0] idx, input logic [7:0] eq);
      logic [19:0] wide;
      logic [3:0]  en;
      en   = eq[7:4];
      wide = 20'(idx) << eq[3:0];
`ifdef ALL_TAPS_ROUND_EN
      wide = wide + 20'd8;
`else
      wide = wide + 20'd0;
`endif
      if (!en[idx[2:1]]) return 16'h0000;
      return wide[19:4];
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         eq_q     <= '0;
         eq_valid <= 1'b0;
         cnt      <= '0;
         stage    <= '0;
         allTaps  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!busy && (!eq_valid || eqVal != eq_q)) begin
                  eq_q     <= eqVal;
                  eq_valid <= 1'b1;
                  cnt      <= '0;
                  state    <= COMPUTE;
               end
            end
            COMPUTE: begin
               // Tap 0 lives in the top word, so the slot base is (7 - cnt) * 16.
               stage[{~cnt, 4'b0000} +: 16] <= tap_val(cnt, eq_q);
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) state <= COMMIT;
            end
            COMMIT: begin
               allTaps <= stage;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_all_taps.sv
// Randomized and directed bench for all_taps with a cycle-level arithmetic reference model.
module tb_all_taps;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   eqVal;
   logic [127:0] allTaps;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0]   cur_eq;
   logic [127:0] cur_exp;

   all_taps dut (.clk(clk), .reset(reset), .eqVal(eqVal), .allTaps(allTaps));

   always #5 clk = ~clk;

   function automatic logic [127:0] model(input logic [7:0] v);
      logic [127:0] r;
      int t;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         t = i * (1 << v[3:0]);
`ifdef ALL_TAPS_ROUND_EN
         t = (t + 8) / 16;
`else
         t = t / 16;
`endif
         if (v[4 + i / 2]) r[127 - 16 * i -: 16] = t[15:0];
      end
      return r;
   endfunction

   task automatic check_now(input logic [127:0] exp, input string tag);
      vectors++;
      assert (allTaps === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h want %h", tag, allTaps, exp);
      end
   endtask

   task automatic step_check(input logic [127:0] exp, input string tag);
      @(posedge clk);
      #1;
      check_now(exp, tag);
   endtask

   // Apply a setting while idle: old value held 9 edges, new value after the 10th.
   task automatic run_cfg(input logic [7:0] v, input string tag);
      eqVal = v;
      if (v != cur_eq) begin
         for (int k = 0; k < 9; k++) step_check(cur_exp, {tag, "_hold"});
         cur_exp = model(v);
         cur_eq  = v;
         step_check(cur_exp, {tag, "_commit"});
      end else begin
         for (int k = 0; k < 10; k++) step_check(cur_exp, {tag, "_steady"});
      end
   endtask

   initial begin
      reset   = 1'b0;
      eqVal   = 8'hF4;
      cur_exp = '0;
      cur_eq  = 8'hF4;
      step_check(128'h0, "reset_state");
      step_check(128'h0, "reset_state2");
      reset = 1'b1;
      for (int k = 0; k < 9; k++) step_check(128'h0, "post_reset_zero");
      cur_exp = model(8'hF4);
      step_check(128'h0000_0001_0002_0003_0004_0005_0006_0007, "first_f4");

      run_cfg(8'hFF, "ff");
      check_now(128'h0000_0800_1000_1800_2000_2800_3000_3800, "ff_const");
      run_cfg(8'h34, "b34");
      check_now(128'h0000_0001_0002_0003_0000_0000_0000_0000, "b34_const");
      run_cfg(8'hF3, "f3");
`ifdef ALL_TAPS_ROUND_EN
      check_now(128'h0000_0001_0001_0002_0002_0003_0003_0004, "f3_const");
`else
      check_now(128'h0000_0000_0001_0001_0002_0002_0003_0003, "f3_const");
`endif
      run_cfg(8'hF3, "f3_same");

      // Change while busy: FF finishes first, then 34 starts at the next idle edge.
      eqVal = 8'hFF;
      for (int k = 0; k < 3; k++) step_check(cur_exp, "busy_old");
      eqVal = 8'h34;
      for (int k = 0; k < 6; k++) step_check(cur_exp, "busy_old2");
      cur_exp = model(8'hFF);
      step_check(cur_exp, "busy_ff_commit");
      for (int k = 0; k < 9; k++) step_check(cur_exp, "busy_ff_hold");
      cur_exp = model(8'h34);
      cur_eq  = 8'h34;
      step_check(cur_exp, "busy_34_commit");

      // Reset mid-computation clears output without a clock edge.
      eqVal = 8'hA7;
      for (int k = 0; k < 4; k++) step_check(cur_exp, "rst_pre");
      #2;
      reset = 1'b0;
      #1;
      check_now(128'h0, "rst_async");
      step_check(128'h0, "rst_held");
      reset   = 1'b1;
      cur_exp = '0;
      for (int k = 0; k < 9; k++) step_check(128'h0, "rst_recover_zero");
      cur_exp = model(8'hA7);
      cur_eq  = 8'hA7;
      step_check(cur_exp, "rst_recover");

      for (int n = 0; n < 24; n++) begin
         logic [7:0] r;
         r = 8'($urandom);
         if (n % 6 == 5) r = cur_eq;
         run_cfg(r, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/all_taps.md
ALL_TAPS -- requirements
Module: all_taps

Interface
REQ-001 No parameters; all widths fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 eqVal  input  8  equalizer setting: [7:4] band-enable nibble EN, [3:0] shift amount S (0..15).
REQ-005 allTaps  output  128  eight 16-bit unsigned tap words, registered; tap i occupies bits [127-16i : 112-16i], so tap0 is the MSB word and tap7 the LSB word.

Function
REQ-006 Tap value: T_i = ((i << S) >> 4) truncated to 16 bits, for i = 0..7; computed in a 20-bit intermediate with no overflow.
REQ-007 Band enable: EN[k] enables taps 2k and 2k+1 (k = 0..3); a disabled tap SHALL be 16'h0000.
REQ-008 Internal state: captured setting eq_q[7:0], flag eq_valid, busy flag, 3-bit tap counter, 128-bit staging register, 128-bit output register driving allTaps.
REQ-009 Start: when idle, a computation starts at edge N if eq_valid=0 or eqVal != eq_q; edge N loads eq_q=eqVal, sets eq_valid=1, busy=1, counter=0.
REQ-010 Compute: edges N+1..N+8 each write tap (counter) from eq_q into the staging register, then increment counter; the increment from 7 wraps to 0.
REQ-011 Commit: edge N+9 copies staging to allTaps in one transfer and clears busy; allTaps never shows a partially updated vector.
REQ-012 Latency: a new eqVal stable before edge N appears on allTaps after edge N+9 (9 cycles).
REQ-013 eqVal changes while busy are ignored; the running computation finishes with eq_q; a new computation starts at the first idle edge where eqVal != eq_q, so the last stable value always wins.
REQ-014 Constant eqVal: no recomputation; allTaps holds its value indefinitely.

Reset
REQ-015 reset=0 asynchronously clears allTaps, the staging register, eq_q, eq_valid, busy and counter to 0.
REQ-016 Reset asserted mid-computation aborts it; allTaps stays 0 until a full computation commits after release.
REQ-017 The first rising edge with reset=1 starts a computation unconditionally (eq_valid=0), so allTaps is valid 9 cycles after release.

Configuration
REQ-018 Macro ALL_TAPS_ROUND_EN: when defined, T_i = ((i << S) + 8) >> 4 (round half up); when undefined, T_i = (i << S) >> 4 (truncate); all other behaviour is identical.

Verification
REQ-019 Reset release, eqVal=8'hF4 held -> within 10 cycles allTaps = 128'h0000_0001_0002_0003_0004_0005_0006_0007, both macro settings.
REQ-020 eqVal 8'hF4 -> 8'hFF -> exactly 9 cycles later allTaps = 128'h0000_0800_1000_1800_2000_2800_3000_3800, with no intermediate value visible.
REQ-021 eqVal=8'h34 -> allTaps = 128'h0000_0001_0002_0003_0000_0000_0000_0000.
REQ-022 eqVal=8'hF3 -> without macro 128'h0000_0000_0001_0001_0002_0002_0003_0003; with ALL_TAPS_ROUND_EN 128'h0000_0001_0001_0002_0002_0003_0003_0004.
REQ-023 eqVal changed to 8'h34 at cycle 3 of an 8'hFF computation -> allTaps first commits the FF result, then the 34 result 9 cycles after the next idle edge.
REQ-024 reset pulsed low mid-computation -> allTaps = 0 immediately, with no clock edge needed; after release, the correct taps appear 9 cycles later.
